// File: rtl/md_mux_pkg.sv
//------------------------------------------------------------------------------
// Module  : md_mux_pkg
// Purpose : Shared width helpers, the FIFO entry type and the MD legality rule
//           for the multi-channel MD receive mux.
//           The entry type is sized from the package configuration constants
//           (MD_ALGN_DW / MD_NUM_CH / MD_FIFO_DEPTH). md_rx_mux_fifo takes its
//           parameter defaults from these constants, so the two must agree.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package md_mux_pkg;

   localparam int MD_ALGN_DW    = 32;
   localparam int MD_NUM_CH     = 4;
   localparam int MD_FIFO_DEPTH = 8;

   // Offset width. It is held at 1 bit minimum so that an 8-bit bus
   // (a single byte lane) still gets a legal port width.
   function automatic int md_ow(input int bw);
      return (bw > 1) ? $clog2(bw) : 1;
   endfunction

   // Size width: has to be able to hold the value BW itself
   function automatic int md_sw(input int bw);
      return $clog2(bw) + 1;
   endfunction

   // Channel index width
   function automatic int md_cw(input int num_ch);
      return $clog2(num_ch);
   endfunction

   // Level width: has to be able to hold the value FIFO_DEPTH itself
   function automatic int md_lw(input int depth);
      return $clog2(depth) + 1;
   endfunction

   typedef struct packed {
      logic [MD_ALGN_DW-1:0]              data;
      logic [md_ow(MD_ALGN_DW/8)-1:0]     offset;
      logic [md_sw(MD_ALGN_DW/8)-1:0]     size;
      logic [md_cw(MD_NUM_CH)-1:0]        ch;
   } md_entry_t;

   // A transfer is legal when it carries at least one byte and does not
   // run past the end of the bus. The sum is formed in 32 bits, so it
   // cannot wrap.
   function automatic logic md_legal(input int unsigned offset,
                                     input int unsigned size,
                                     input int unsigned bw);
      return (size != 0) && ((offset + size) <= bw);
   endfunction

endpackage

`default_nettype wire

// File: rtl/md_sync_fifo.sv
//------------------------------------------------------------------------------
// Module  : md_sync_fifo
// Purpose : Single-clock FIFO with show-ahead read and a registered level.
// Ports   : clk, reset_n (async, active-high)
//           i_push / i_din        - write port. A push while full is ignored.
//           i_pop  / o_dout       - read port. o_dout shows the head entry.
//                                   A pop while empty is ignored.
//           o_full, o_empty, o_lvl - status, all taken from the registered level.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_sync_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 8,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_din,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_dout,
   output logic             o_full,
   output logic             o_empty,
   output logic [LW-1:0]    o_lvl
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [LW-1:0]    r_lvl;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_lvl == LW'(DEPTH));
   assign o_empty = (r_lvl == '0);
   assign o_lvl   = r_lvl;
   assign o_dout  = r_mem[r_rd_ptr];

   // Full is judged on the registered level only, so a pop in the same
   // cycle never makes room for a push while full.
   assign w_push = i_push & ~o_full;
   assign w_pop  = i_pop  & ~o_empty;

   // DEPTH is a power of two, so the pointers wrap on their own
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_lvl    <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_lvl <= r_lvl + LW'(1);
            2'b01:   r_lvl <= r_lvl - LW'(1);
            default: r_lvl <= r_lvl;
         endcase
      end
   end

   // Storage needs no reset. An entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

`default_nettype wire

// File: rtl/md_rx_mux_fifo.sv
//------------------------------------------------------------------------------
// Module  : md_rx_mux_fifo
// Purpose : Multi-channel MD receive front end. It checks each RX channel for
//           legality and arbitrates the channels round-robin. Legal transfers
//           are queued in one shared FIFO, tagged with their source channel.
//           The queue drains through a single MD TX stream. The block also
//           reports the fill level and raises a sticky FIFO-full irq.
// Option  : MD_MUX_STATS_EN - adds ch_acc_cnt, one 16-bit saturating
//           count of legal accepted transfers per channel. The counts are
//           cleared by irq_clr.
// Ports   : clk, reset_n (async, active-high)
//           ch_enable[NUM_CH]   - a disabled channel is never granted
//           md_rx_valid/data/offset/size - per-channel MD RX inputs
//           md_rx_ready/err     - per-channel handshake; err is only
//                                 meaningful when ready is high
//           md_tx_valid/data/offset/size/ch, md_tx_ready - MD TX output
//           fifo_lvl            - shared FIFO occupancy
//           irq, irq_clr        - sticky full interrupt and its clear
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module md_rx_mux_fifo
   import md_mux_pkg::*;
#(
   parameter  int ALGN_DATA_WIDTH = MD_ALGN_DW,
   parameter  int NUM_CH          = MD_NUM_CH,
   parameter  int FIFO_DEPTH      = MD_FIFO_DEPTH,
   localparam int BW              = ALGN_DATA_WIDTH / 8,
   localparam int OW              = md_ow(BW),
   localparam int SW              = md_sw(BW),
   localparam int CW              = md_cw(NUM_CH),
   localparam int LW              = md_lw(FIFO_DEPTH)
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic [NUM_CH-1:0]             ch_enable,
   input  logic [NUM_CH-1:0]             md_rx_valid,
   input  logic [NUM_CH*ALGN_DATA_WIDTH-1:0] md_rx_data,
   input  logic [NUM_CH*OW-1:0]          md_rx_offset,
   input  logic [NUM_CH*SW-1:0]          md_rx_size,
   output logic [NUM_CH-1:0]             md_rx_ready,
   output logic [NUM_CH-1:0]             md_rx_err,
   output logic                          md_tx_valid,
   output logic [ALGN_DATA_WIDTH-1:0]    md_tx_data,
   output logic [OW-1:0]                 md_tx_offset,
   output logic [SW-1:0]                 md_tx_size,
   output logic [CW-1:0]                 md_tx_ch,
   input  logic                          md_tx_ready,
   output logic [LW-1:0]                 fifo_lvl,
   input  logic                          irq_clr,
   output logic                          irq
`ifdef MD_MUX_STATS_EN
   ,
   output logic [NUM_CH*16-1:0]          ch_acc_cnt
`endif
);

   logic [CW-1:0]     r_rr_ptr;
   logic              r_irq;
   logic [NUM_CH-1:0] w_legal;
   logic [NUM_CH-1:0] w_cand;
   logic              w_gnt_vld;
   logic [CW-1:0]     w_gnt;
   logic              w_push;
   logic              w_pop;
   logic              w_full;
   logic              w_empty;
   md_entry_t         w_din;
   md_entry_t         w_dout;

   // Per-channel legality and grantability. Only a legal transfer needs FIFO
   // space, so an illegal one can still be answered while the FIFO is full.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_legal[gi] = md_legal(32'(md_rx_offset[gi*OW +: OW]),
                                    32'(md_rx_size[gi*SW +: SW]),
                                    32'(BW));
      assign w_cand[gi]  = md_rx_valid[gi] & ch_enable[gi] &
                           (~w_legal[gi] | ~w_full);
   end

   // Round-robin search, starting at r_rr_ptr. The grant is held off while
   // reset is asserted, so no ready is returned during reset.
   always_comb begin
      int s;
      logic [CW-1:0] idx;
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         s = 32'(r_rr_ptr) + k;
         if (s >= NUM_CH) s = s - NUM_CH;
         idx = CW'(s);
         if (!w_gnt_vld && w_cand[idx]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = idx;
         end
      end
      if (reset_n) w_gnt_vld = 1'b0;
   end

   assign md_rx_ready = w_gnt_vld ? (NUM_CH'(1) << w_gnt) : '0;
   assign md_rx_err   = md_rx_ready & ~w_legal;
   assign w_push      = w_gnt_vld & w_legal[w_gnt];

   always_comb begin
      w_din        = '0;
      w_din.data   = md_rx_data[w_gnt*ALGN_DATA_WIDTH +: ALGN_DATA_WIDTH];
      w_din.offset = md_rx_offset[w_gnt*OW +: OW];
      w_din.size   = md_rx_size[w_gnt*SW +: SW];
      w_din.ch     = w_gnt;
   end

   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_rr_ptr <= '0;
      end else if (w_gnt_vld) begin
         r_rr_ptr <= (w_gnt == CW'(NUM_CH - 1)) ? '0 : w_gnt + CW'(1);
      end
   end

   md_sync_fifo #(
      .WIDTH ($bits(md_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_din   (w_din),
      .i_pop   (w_pop),
      .o_dout  (w_dout),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_lvl   (fifo_lvl)
   );

   // The head fields read as zero while the FIFO is empty, so unwritten
   // storage never shows on the outputs.
   assign md_tx_valid  = ~w_empty;
   assign md_tx_data   = md_tx_valid ? w_dout.data   : '0;
   assign md_tx_offset = md_tx_valid ? w_dout.offset : '0;
   assign md_tx_size   = md_tx_valid ? w_dout.size   : '0;
   assign md_tx_ch     = md_tx_valid ? w_dout.ch     : '0;
   assign w_pop        = md_tx_valid & md_tx_ready;

   // irq fires only on the step from DEPTH-1 up to DEPTH. Staying at
   // DEPTH after a clear does not raise it again. A set wins over a clear
   // in the same cycle.
   always_ff @(posedge clk or posedge reset_n) begin
      if (reset_n) begin
         r_irq <= 1'b0;
      end else if (w_push && !w_pop && (fifo_lvl == LW'(FIFO_DEPTH - 1))) begin
         r_irq <= 1'b1;
      end else if (irq_clr) begin
         r_irq <= 1'b0;
      end
   end

   assign irq = r_irq;

`ifdef MD_MUX_STATS_EN
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_stats
      logic [15:0] r_cnt;
      always_ff @(posedge clk or posedge reset_n) begin
         if (reset_n) begin
            r_cnt <= '0;
         end else if (irq_clr) begin
            r_cnt <= '0;
         end else if (w_push && (w_gnt == CW'(gi)) && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
         end
      end
      assign ch_acc_cnt[gi*16 +: 16] = r_cnt;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_md_rx_mux_fifo.sv
//------------------------------------------------------------------------------
// Module  : tb_md_rx_mux_fifo
// Purpose : Self-checking bench for md_rx_mux_fifo (W=32, NUM_CH=4, DEPTH=8).
//           A predictor derives the grants, level and irq from the MD rules
//           and queues the expected TX entries. A separate monitor pops the
//           queue and compares whenever the DUT hands over a TX entry.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_md_rx_mux_fifo;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int D  = 8;
   localparam int BW = 4;

   typedef struct {
      logic [31:0] d;
      int          o;
      int          s;
      int          c;
   } ent_t;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [N-1:0]    ch_enable;
   logic [N-1:0]    md_rx_valid;
   logic [N*DW-1:0] md_rx_data;
   logic [N*2-1:0]  md_rx_offset;
   logic [N*3-1:0]  md_rx_size;
   logic [N-1:0]    md_rx_ready;
   logic [N-1:0]    md_rx_err;
   logic            md_tx_valid;
   logic [31:0]     md_tx_data;
   logic [1:0]      md_tx_offset;
   logic [2:0]      md_tx_size;
   logic [1:0]      md_tx_ch;
   logic            md_tx_ready;
   logic [3:0]      fifo_lvl;
   logic            irq_clr;
   logic            irq;
`ifdef MD_MUX_STATS_EN
   logic [N*16-1:0] ch_acc_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Stimulus state, one slot per channel
   bit          pend [N];
   bit          acc  [N];
   bit          en   [N];
   logic [31:0] dat  [N];
   logic [1:0]  off  [N];
   logic [2:0]  sz   [N];
   int          refill;

   // Reference model state
   ent_t sb[$];
   int   lvl_m;
   int   rr_m;
   bit   irq_m;
   int   cnt_m [N];

   md_rx_mux_fifo dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ch_enable    (ch_enable),
      .md_rx_valid  (md_rx_valid),
      .md_rx_data   (md_rx_data),
      .md_rx_offset (md_rx_offset),
      .md_rx_size   (md_rx_size),
      .md_rx_ready  (md_rx_ready),
      .md_rx_err    (md_rx_err),
      .md_tx_valid  (md_tx_valid),
      .md_tx_data   (md_tx_data),
      .md_tx_offset (md_tx_offset),
      .md_tx_size   (md_tx_size),
      .md_tx_ch     (md_tx_ch),
      .md_tx_ready  (md_tx_ready),
      .fifo_lvl     (fifo_lvl),
      .irq_clr      (irq_clr),
      .irq          (irq)
`ifdef MD_MUX_STATS_EN
      ,
      .ch_acc_cnt   (ch_acc_cnt)
`endif
   );

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < N; gi++) begin : g_drv
      assign md_rx_valid[gi]             = pend[gi];
      assign ch_enable[gi]               = en[gi];
      assign md_rx_data[gi*DW +: DW]     = dat[gi];
      assign md_rx_offset[gi*2 +: 2]     = off[gi];
      assign md_rx_size[gi*3 +: 3]       = sz[gi];
   end

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, a, e, $time);
      end
   endtask

   function automatic bit legal(input int o, input int s);
      return (s != 0) && (o + s <= BW);
   endfunction

   // Predictor: decides what this cycle has to look like, then advances the
   // model to the state after the coming rising edge.
   always @(negedge clk) begin
      int g, c, nl;
      bit push, pop;
      logic [N-1:0] er, ee;
      if (reset_n) begin
         chk("rst_ready", md_rx_ready, 0);
         chk("rst_tx_valid", md_tx_valid, 0);
         chk("rst_lvl", fifo_lvl, 0);
         chk("rst_irq", irq, 0);
         sb.delete();
         lvl_m = 0; rr_m = 0; irq_m = 0;
         for (int i = 0; i < N; i++) begin acc[i] = 0; cnt_m[i] = 0; end
      end else begin
         g = -1;
         for (int k = 0; k < N; k++) begin
            c = (rr_m + k) % N;
            if (g < 0 && pend[c] && en[c] &&
                (!legal(int'(off[c]), int'(sz[c])) || lvl_m < D)) g = c;
         end
         er = (g >= 0) ? (N'(1) << g) : '0;
         ee = (g >= 0 && !legal(int'(off[g]), int'(sz[g]))) ? er : '0;
         chk("rx_ready", md_rx_ready, er);
         chk("rx_err", md_rx_err, ee);
         chk("tx_valid", md_tx_valid, lvl_m > 0);
         chk("fifo_lvl", fifo_lvl, lvl_m);
         chk("irq", irq, irq_m);
`ifdef MD_MUX_STATS_EN
         for (int i = 0; i < N; i++) chk("acc_cnt", ch_acc_cnt[i*16 +: 16], cnt_m[i]);
`endif
         push = (g >= 0) && (ee == '0);
         pop  = (lvl_m > 0) && md_tx_ready;
         if (push) begin
            ent_t e;
            e.d = dat[g]; e.o = int'(off[g]); e.s = int'(sz[g]); e.c = g;
            sb.push_back(e);
         end
         for (int i = 0; i < N; i++) acc[i] = (g == i);
         if (g >= 0) rr_m = (g + 1) % N;
         nl = lvl_m + (push ? 1 : 0) - (pop ? 1 : 0);
         if (nl == D && lvl_m != D) irq_m = 1;
         else if (irq_clr)          irq_m = 0;
         if (irq_clr) begin
            for (int i = 0; i < N; i++) cnt_m[i] = 0;
         end else if (push && cnt_m[g] < 65535) begin
            cnt_m[g]++;
         end
         lvl_m = nl;
      end
   end

   // Monitor: every TX handshake has to match the oldest expected entry
   always @(negedge clk) begin
      if (!reset_n && md_tx_valid && md_tx_ready) begin
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL tx_unexpected actual=%0h required=none at %0t", md_tx_data, $time);
         end else begin
            ent_t e;
            e = sb.pop_front();
            chk("tx_data", md_tx_data, e.d);
            chk("tx_offset", md_tx_offset, e.o);
            chk("tx_size", md_tx_size, e.s);
            chk("tx_ch", md_tx_ch, e.c);
         end
      end
   end

   task automatic newreq(input int i, input int o, input int s);
      pend[i] = 1;
      off[i]  = 2'(o);
      sz[i]   = 3'(s);
      dat[i]  = $urandom;
   endtask

   // Advance one cycle per iteration. Inputs change 1 time unit after the
   // rising edge; accepted channels are released, then optionally refilled.
   task automatic step(input int n);
      int s;
      repeat (n) begin
         @(posedge clk); #1;
         for (int i = 0; i < N; i++) begin
            if (acc[i]) pend[i] = 0;
            if (!pend[i] && refill == 1) begin
               s = $urandom_range(1, 4);
               newreq(i, $urandom_range(0, 4 - s), s);
            end else if (!pend[i] && refill == 2 && $urandom_range(0, 99) < 60) begin
               newreq(i, $urandom_range(0, 3), $urandom_range(0, 4));
            end
         end
         if (refill == 2) begin
            md_tx_ready = ($urandom_range(0, 99) < 65);
            irq_clr     = ($urandom_range(0, 99) < 5);
            for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 99) < 85);
         end
      end
   endtask

   function automatic bit any_pend();
      bit r = 0;
      for (int i = 0; i < N; i++) r |= pend[i];
      return r;
   endfunction

   task automatic wait_idle();
      int t = 0;
      md_tx_ready = 1;
      while ((any_pend() || lvl_m != 0) && t < 300) begin
         step(1);
         t++;
      end
      checks++;
      if (t >= 300) begin
         errors++;
         $display("FAIL idle_timeout actual=busy required=idle at %0t", $time);
      end
   endtask

   initial begin
      reset_n     = 1;
      md_tx_ready = 1;
      irq_clr     = 0;
      refill      = 0;
      for (int i = 0; i < N; i++) begin
         en[i] = 1; pend[i] = 0; acc[i] = 0;
         dat[i] = '0; off[i] = '0; sz[i] = '0;
      end

      // Reset with every channel requesting
      for (int i = 0; i < N; i++) newreq(i, 0, 4);
      step(3);
      chk("rst_ready_dir", md_rx_ready, 0);
      reset_n = 0;

      // Round-robin with all channels continuously valid
      refill = 1;
      step(12);
      refill = 0;
      wait_idle();

      // Legality checks on ch1 with the output stalled
      md_tx_ready = 0;
      newreq(1, 2, 3); step(1);
      chk("ill_sum_lvl", fifo_lvl, 0);
      newreq(1, 0, 0); step(1);
      chk("ill_zero_lvl", fifo_lvl, 0);
      newreq(1, 1, 3); step(1);
      chk("legal_lvl", fifo_lvl, 1);
      wait_idle();

      // Fill to full, then backpressure
      md_tx_ready = 0;
      for (int k = 0; k < D; k++) begin newreq(0, 0, 4); step(1); end
      chk("full_lvl", fifo_lvl, D);
      chk("full_irq", irq, 1);
      newreq(2, 1, 2); step(3);
      chk("ch2_held", pend[2], 1);
      newreq(3, 3, 3); step(1);
      chk("ch3_ill_full", pend[3], 0);
      md_tx_ready = 1; step(1);
      md_tx_ready = 0; step(1);
      chk("ch2_after_pop", pend[2], 0);
      irq_clr = 1; step(1); irq_clr = 0;
      wait_idle();

      // irq set racing a clear, then a clear while staying full
      md_tx_ready = 0;
      for (int k = 0; k < D - 1; k++) begin newreq(0, 0, 4); step(1); end
      newreq(0, 0, 4); irq_clr = 1; step(1); irq_clr = 0;
      chk("irq_race", irq, 1);
      irq_clr = 1; step(1); irq_clr = 0;
      chk("irq_clr_full", irq, 0);
      step(3);
      chk("irq_no_reset", irq, 0);
      wait_idle();

      // Disabled channel stalls, then is accepted on re-enable
      en[1] = 0;
      newreq(1, 1, 2);
      step(20);
      chk("en_stall", pend[1], 1);
      en[1] = 1;
      step(1);
      chk("en_accept", pend[1], 0);
      wait_idle();

      // Reset in the middle of traffic drops all entries
      md_tx_ready = 0;
      refill = 1;
      step(5);
      reset_n = 1;
      step(2);
      chk("mid_rst_lvl", fifo_lvl, 0);
      chk("mid_rst_valid", md_tx_valid, 0);
      reset_n = 0;
      refill = 0;
      wait_idle();

      // Randomised traffic
      refill = 2;
      step(3000);
      refill = 0;
      irq_clr = 0;
      for (int i = 0; i < N; i++) en[i] = 1;
      wait_idle();
      chk("end_sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

endmodule

`default_nettype wire
